// File: rtl/trap_sequencer_pkg.sv
// Shared types and constants for the trap sequencer: FSM states, commit kinds
// and the machine-mode cause codes used to build mcause values.
package trap_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  typedef enum logic {
    KIND_TRAP = 1'b0,
    KIND_RET  = 1'b1
  } kind_t;

  // Synchronous exception codes reported by the execute stage.
  typedef enum logic [3:0] {
    EXC_INSTR_MISALIGN = 4'd0,
    EXC_INSTR_FAULT    = 4'd1,
    EXC_ILLEGAL_INSTR  = 4'd2,
    EXC_BREAKPOINT     = 4'd3,
    EXC_LOAD_MISALIGN  = 4'd4,
    EXC_LOAD_FAULT     = 4'd5,
    EXC_STORE_MISALIGN = 4'd6,
    EXC_STORE_FAULT    = 4'd7,
    EXC_ECALL_U        = 4'd8,
    EXC_ECALL_S        = 4'd9,
    EXC_RESERVED_10    = 4'd10,
    EXC_ECALL_M        = 4'd11
  } exc_code_e;

  // Interrupt cause numbers share the 4-bit code space with exceptions.
  localparam logic [3:0] IRQ_MEI = 4'd11;
  localparam logic [3:0] IRQ_MTI = 4'd7;

endpackage

// File: rtl/trap_sequencer_if.sv
// Pipeline/CSR-facing signal bundle of the trap sequencer. The sequencer uses
// the slave modport; the pipeline/CSR side (or a bench) uses master.
interface trap_sequencer_if
  import trap_sequencer_pkg::*;
#(
  parameter int XLEN = 32
);

  // Requests are level-sampled each cycle while the sequencer is idle and
  // stall is low; there is no ready back-pressure. Commit outputs are
  // one-cycle strobes, and m_cause/pc_exc are meaningful only alongside
  // exception_pending.
  logic            exc_valid;
  logic [3:0]      exc_code;
  logic [XLEN-1:0] exc_pc;
  logic            instr_valid;
  logic [XLEN-1:0] instr_pc;
  logic            mret_req;
  logic            irq_ext;
  logic            irq_timer;
  logic            m_eie;
  logic            m_tie;
  logic            stall_in;

  logic            busy;
  logic            flush;
  logic            exception_pending;
  logic            m_ret;
  logic [XLEN-1:0] m_cause;
  logic [XLEN-1:0] pc_exc;
  logic            asy_int;
  logic            pcsel_trap;
  logic            pcsel_ret;
  state_t          dbg_state;

  modport master (
    output exc_valid, exc_code, exc_pc, instr_valid, instr_pc, mret_req,
    output irq_ext, irq_timer, m_eie, m_tie, stall_in,
    input  busy, flush, exception_pending, m_ret, m_cause, pc_exc,
    input  asy_int, pcsel_trap, pcsel_ret, dbg_state
  );

  modport slave (
    input  exc_valid, exc_code, exc_pc, instr_valid, instr_pc, mret_req,
    input  irq_ext, irq_timer, m_eie, m_tie, stall_in,
    output busy, flush, exception_pending, m_ret, m_cause, pc_exc,
    output asy_int, pcsel_trap, pcsel_ret, dbg_state
  );

endinterface

// File: rtl/trap_sequencer_prio_enc.sv
// Combinational priority select between sync exception, enabled interrupts
// and MRET; produces the candidate kind, cause and saved PC for one cycle.
module trap_prio_enc
  import trap_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            exc_valid,
  input  logic [3:0]      exc_code,
  input  logic [XLEN-1:0] exc_pc,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] instr_pc,
  input  logic            mret_req,
  input  logic            ext_pend,
  input  logic            tim_pend,
  output logic            take,
  output kind_t           kind,
  output logic [XLEN-1:0] cause,
  output logic [XLEN-1:0] pc
);

  always_comb begin
    take  = 1'b0;
    kind  = KIND_TRAP;
    cause = '0;
    pc    = '0;
    if (exc_valid) begin
      take  = 1'b1;
      cause = {1'b0, {(XLEN-5){1'b0}}, exc_code};
      pc    = exc_pc;
    // A pending interrupt needs a real instruction to return to; until one
    // is in execute it also holds off lower-priority MRET.
    end else if (ext_pend) begin
      take  = instr_valid;
      cause = {1'b1, {(XLEN-5){1'b0}}, IRQ_MEI};
      pc    = instr_pc;
    end else if (tim_pend) begin
      take  = instr_valid;
      cause = {1'b1, {(XLEN-5){1'b0}}, IRQ_MTI};
      pc    = instr_pc;
    end else if (mret_req) begin
      take  = 1'b1;
      kind  = KIND_RET;
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Trap/MRET sequencer: captures the highest-priority event in IDLE, flushes,
// drains in-flight writebacks, then emits a single commit strobe to the CSRs.
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int XLEN         = 32
) (
  input logic              clk,
  input logic              nrst,
  trap_sequencer_if.slave  bus
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t          state_q, state_d;
  kind_t           kind_q, kind_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] pc_q, pc_d;

  logic            take;
  kind_t           sel_kind;
  logic [XLEN-1:0] sel_cause;
  logic [XLEN-1:0] sel_pc;
  logic            capture;

  trap_prio_enc #(.XLEN(XLEN)) u_prio (
    .exc_valid   (bus.exc_valid),
    .exc_code    (bus.exc_code),
    .exc_pc      (bus.exc_pc),
    .instr_valid (bus.instr_valid),
    .instr_pc    (bus.instr_pc),
    .mret_req    (bus.mret_req),
    .ext_pend    (bus.irq_ext & bus.m_eie),
    .tim_pend    (bus.irq_timer & bus.m_tie),
    .take        (take),
    .kind        (sel_kind),
    .cause       (sel_cause),
    .pc          (sel_pc)
  );

  // Gated by nrst so every output is quiet while reset is held.
  assign capture = nrst && (state_q == ST_IDLE) && !bus.stall_in && take;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      kind_q  <= KIND_TRAP;
      cnt_q   <= '0;
      cause_q <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    pc_d    = pc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (capture) begin
          state_d = ST_DRAIN;
          kind_d  = sel_kind;
          cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
          // MRET leaves the last trap's cause/PC untouched.
          if (sel_kind == KIND_TRAP) begin
            cause_d = sel_cause;
            pc_d    = sel_pc;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = ST_COMMIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  logic commit_trap;
  logic commit_ret;

  assign commit_trap = (state_q == ST_COMMIT) && (kind_q == KIND_TRAP);
  assign commit_ret  = (state_q == ST_COMMIT) && (kind_q == KIND_RET);

  assign bus.busy              = capture || (state_q != ST_IDLE);
  assign bus.flush             = capture;
  assign bus.exception_pending = commit_trap;
  assign bus.pcsel_trap        = commit_trap;
  assign bus.asy_int           = commit_trap && cause_q[XLEN-1];
  assign bus.m_ret             = commit_ret;
  assign bus.pcsel_ret         = commit_ret;
  assign bus.m_cause           = cause_q;
  assign bus.pc_exc            = pc_q;
  assign bus.dbg_state         = state_q;

endmodule
